// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer.
//   ser_state_t : FSM state encoding (idle / shifting out beats)
//   beats_f     : number of beats a word splits into, used for derived-parameter checks
package serializer_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  function automatic int unsigned beats_f(input int unsigned word_w, input int unsigned beat_w);
    return word_w / beat_w;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat index counter for the word serializer.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset, clears the count
//   clr      : restart at beat 0 (a new word was loaded); wins over inc
//   inc      : advance one beat, wrapping from MAX back to 0
//   o_count  : current beat index
//   o_at_max : count is on the final beat (MAX)
module beat_counter #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_at_max
);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_count  = count_q;
  assign o_at_max = (count_q == CNT_W'(MAX));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = o_at_max ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Unpacks one WORD_WIDTH word into WORD_WIDTH/BEAT_WIDTH beats on a valid/ready stream,
// marking the final beat of each word with o_last.
// Build option: define WORD_SERIALIZER_MSB_FIRST_EN to send the most significant beat first;
// by default the least significant beat goes first.
// Ports:
//   clk, reset : clock, synchronous active-high reset (dominates clk_en)
//   clk_en     : global advance enable; low freezes the block and drops o_valid/o_ready
//   i_valid, i_data, o_ready : word input handshake
//   o_valid, o_data, o_last, i_ready : beat output handshake
module word_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH  = 32,
  parameter int unsigned           BEAT_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BEAT_WIDTH-1:0] o_data,
  output logic                  o_last
);

  localparam int unsigned BEATS = beats_f(WORD_WIDTH, BEAT_WIDTH);
  localparam int unsigned CNT_W = (BEATS < 2) ? 1 : $clog2(BEATS);

  if ((WORD_WIDTH % BEAT_WIDTH) != 0 || BEATS < 2) begin : g_param_check
    $error("word_serializer: WORD_WIDTH must be a multiple of BEAT_WIDTH with at least 2 beats");
  end

  ser_state_t                       state_q, state_d;
  logic                             valid_q, valid_d;
  logic [WORD_WIDTH-1:0]            word_q;
  logic                             load;
  logic [CNT_W-1:0]                 cnt;
  logic                             at_max;
  logic                             word_acc;
  logic                             beat_xfer;
  logic [CNT_W-1:0]                 beat_idx;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] beats;

  assign word_acc  = i_valid && o_ready;
  assign beat_xfer = o_valid && i_ready;

  assign o_valid = valid_q && clk_en;
  assign o_last  = valid_q && at_max;
  // Accepting on the last beat's transfer keeps back-to-back words bubble-free.
  assign o_ready = clk_en && (state_q == SER_IDLE || (valid_q && o_last && i_ready));

  beat_counter #(
    .CNT_W (CNT_W),
    .MAX   (BEATS - 1)
  ) u_beat_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (load),
    .inc      (beat_xfer),
    .o_count  (cnt),
    .o_at_max (at_max)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    load    = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        if (word_acc) begin
          state_d = SER_SHIFT;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      SER_SHIFT: begin
        if (beat_xfer && at_max) begin
          if (word_acc) begin
            load = 1'b1;
          end else begin
            state_d = SER_IDLE;
            valid_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      valid_q <= 1'b0;
      word_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (load) begin
        word_q <= i_data;
      end
    end
  end

  // Packed view: beats[k] is word bits [k*BEAT_WIDTH +: BEAT_WIDTH].
  assign beats = word_q;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
  assign beat_idx = CNT_W'(BEATS - 1) - cnt;
`else
  assign beat_idx = cnt;
`endif

  assign o_data = beats[beat_idx];

`ifdef FORMAL
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (o_valid && !i_ready) |=> ($stable(o_data) && $stable(o_last)));
  a_count_range: assert property (@(posedge clk) (32'(cnt) < BEATS));
  a_reset_idle: assert property (@(posedge clk) reset |=> !o_valid);
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (32-bit words, 8-bit beats).
// Inputs change just after the falling edge and outputs are sampled 1 time unit later,
// well away from the rising edge. Beat order follows WORD_SERIALIZER_MSB_FIRST_EN.
module tb_word_serializer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_serializer #(
    .WORD_WIDTH  (32),
    .BEAT_WIDTH  (8),
    .RESET_VALUE (32'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last)
  );

  // k-th beat leaving the block for word w.
  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
    return 8'((w >> (8 * (NB - 1 - k))) & 32'hFF);
`else
    return 8'((w >> (8 * k)) & 32'hFF);
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", o_last); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    clk_en = 1'b0;
    #1;
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_noen: got %b expected 0", o_ready); end
    clk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hDDCCBBAA;
    i_valid = 1'b1; i_data = w; i_ready = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept_ready: got %b expected 1", o_ready); end
    @(negedge clk);
    i_valid = 1'b0; i_data = $urandom;
    for (int k = 0; k < NB; k++) begin
      #1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", k, o_valid); end
      n_checks++; if (o_data !== exp_beat(w, k)) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, o_data, exp_beat(w, k)); end
      n_checks++; if (o_last !== (k == NB - 1)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", k, o_last, (k == NB - 1)); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_done_valid: got %b expected 0", o_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2];
    logic [7:0]  e;
    w[0] = 32'h03020100; w[1] = 32'h07060504;
    i_valid = 1'b1; i_data = w[0]; i_ready = 1'b1;
    @(negedge clk);
    i_data = w[1];
    for (int k = 0; k < 2 * NB; k++) begin
      #1;
      e = exp_beat(w[k / NB], k % NB);
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, o_valid); end
      n_checks++; if (o_data !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, o_data, e); end
      n_checks++; if (o_last !== (k % NB == NB - 1)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b expected %b", k, o_last, (k % NB == NB - 1)); end
      if (k < NB) begin
        n_checks++; if (o_ready !== (k == NB - 1)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, o_ready, (k == NB - 1)); end
      end
      @(negedge clk);
      if (k == NB - 1) begin
        i_valid = 1'b0; i_data = $urandom;
      end
    end
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_valid: got %b expected 0", o_valid); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    int          rdy [7] = '{1, 0, 0, 0, 1, 1, 1};
    int          idx [7] = '{0, 1, 1, 1, 1, 2, 3};
    w = 32'hDDCCBBAA;
    i_valid = 1'b1; i_data = w; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_data = $urandom;
    // Seven cycles: one beat, three stalled cycles, then the remaining three beats.
    for (int c = 0; c < 7; c++) begin
      i_ready = rdy[c][0];
      #1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, o_valid); end
      n_checks++; if (o_data !== exp_beat(w, idx[c])) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", c, o_data, exp_beat(w, idx[c])); end
      n_checks++; if (o_last !== (c == 6)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", c, o_last, (c == 6)); end
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %b expected 0", o_valid); end
    @(negedge clk);
  endtask

  task automatic test_clk_en_stall();
    logic [31:0] w;
    int          en  [6] = '{1, 0, 0, 1, 1, 1};
    int          idx [6] = '{0, 1, 1, 1, 2, 3};
    w = 32'h88776655;
    i_valid = 1'b1; i_data = w; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_data = $urandom;
    for (int c = 0; c < 6; c++) begin
      clk_en = en[c][0];
      // Offer a word during the freeze: it must not be taken.
      i_valid = !en[c][0];
      #1;
      n_checks++; if (o_valid !== en[c][0]) begin n_fail++; $display("FAIL en_valid[%0d]: got %b expected %b", c, o_valid, en[c][0]); end
      n_checks++; if (o_data !== exp_beat(w, idx[c])) begin n_fail++; $display("FAIL en_data[%0d]: got %h expected %h", c, o_data, exp_beat(w, idx[c])); end
      n_checks++; if (o_last !== (c == 5)) begin n_fail++; $display("FAIL en_last[%0d]: got %b expected %b", c, o_last, (c == 5)); end
      if (!en[c][0]) begin
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready[%0d]: got %b expected 0", c, o_ready); end
      end
      @(negedge clk);
    end
    clk_en = 1'b1; i_valid = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL en_done_valid: got %b expected 0", o_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    i_valid = 1'b1; i_data = 32'hDDCCBBAA; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_data = $urandom;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", o_ready); end
    n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last: got %b expected 0", o_last); end
    w = 32'h44332211;
    i_valid = 1'b1; i_data = w;
    @(negedge clk);
    i_valid = 1'b0; i_data = $urandom;
    for (int k = 0; k < NB; k++) begin
      #1;
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat_valid[%0d]: got %b expected 1", k, o_valid); end
      n_checks++; if (o_data !== exp_beat(w, k)) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h expected %h", k, o_data, exp_beat(w, k)); end
      n_checks++; if (o_last !== (k == NB - 1)) begin n_fail++; $display("FAIL rstmid_last[%0d]: got %b expected %b", k, o_last, (k == NB - 1)); end
      @(negedge clk);
    end
  endtask

  // Random traffic against a queue of beats still owed for the current word.
  task automatic test_random();
    logic [7:0] q[$];
    logic       exp_valid, exp_ready, exp_last;
    logic [31:0] w;
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 99) < 2);
      clk_en  = ($urandom_range(0, 99) < 85);
      i_valid = ($urandom_range(0, 99) < 50);
      i_ready = ($urandom_range(0, 99) < 70);
      i_data  = $urandom;
      #1;
      exp_valid = clk_en && (q.size() != 0);
      exp_last  = (q.size() == 1);
      exp_ready = clk_en && ((q.size() == 0) || (q.size() == 1 && i_ready));
      n_checks++; if (o_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, o_valid, exp_valid); end
      n_checks++; if (o_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, o_ready, exp_ready); end
      n_checks++; if (o_last !== exp_last) begin n_fail++; $display("FAIL rand_last[%0d]: got %b expected %b", c, o_last, exp_last); end
      if (q.size() != 0) begin
        n_checks++; if (o_data !== q[0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, o_data, q[0]); end
      end
      if (reset) begin
        q.delete();
      end else if (clk_en) begin
        if (q.size() != 0 && i_ready) void'(q.pop_front());
        if (i_valid && exp_ready) begin
          w = i_data;
          for (int k = 0; k < NB; k++) q.push_back(exp_beat(w, k));
        end
      end
      @(negedge clk);
    end
    reset = 1'b0; clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < NB + 1; c++) @(negedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain_valid: got %b expected 0", o_valid); end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_clk_en_stall();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
